// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time,
// and holds each fetched word for decode until it is consumed or a redirect arrives.
module pc_fetch_ctrl #(
  parameter int unsigned         REG_BITS     = 32,
  parameter logic [REG_BITS-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [REG_BITS-1:0] redirect_target,
  output logic                imem_req,
  output logic [REG_BITS-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [REG_BITS-1:0] imem_rdata,
  output logic                inst_valid,
  output logic [REG_BITS-1:0] inst,
  output logic [REG_BITS-1:0] inst_pc,
  output logic [REG_BITS-1:0] pc_out,
  output logic [31:0]         fetch_count
);

  localparam logic [REG_BITS-1:0] INC        = (REG_BITS == 32) ? REG_BITS'(4) : REG_BITS'(2);
  localparam logic [REG_BITS-1:0] ALIGN_MASK = (REG_BITS == 32) ? ~REG_BITS'(3) : ~REG_BITS'(1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [REG_BITS-1:0] pc_q, pc_d;
  logic [REG_BITS-1:0] inst_q, inst_d;
  logic [REG_BITS-1:0] inst_pc_q, inst_pc_d;
  logic                inst_valid_q, inst_valid_d;
  logic [31:0]         count_q, count_d;
  logic [REG_BITS-1:0] target_aligned;

  assign target_aligned = redirect_target & ALIGN_MASK;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    count_d      = count_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect_valid) pc_d = target_aligned;
      end
      FETCH: begin
        // A redirect changes the address under the live request; that is the abort.
        if (redirect_valid) begin
          pc_d = target_aligned;
        end else if (imem_ack) begin
          inst_d       = imem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + INC;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          inst_valid_d = 1'b0;
          pc_d         = target_aligned;
          state_d      = FETCH;
        end else if (!stall) begin
          count_d      = count_q + 32'd1;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      count_q      <= count_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign fetch_count = count_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer that owns the program counter register and drives instruction-memory requests. It issues one outstanding fetch at a time and waits a variable number of cycles for the memory acknowledge. It then presents the instruction to decode with a valid/stall handshake and advances the PC by the instruction size. Branch/jump redirects from execute override sequential flow at any point, including aborting an in-flight fetch.

Parameters:
REG_BITS, 32, width of PC, addresses and instruction word; PC increment INC is 4 when REG_BITS==32, else 2.
RESET_VECTOR, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  decode cannot accept the presented instruction this cycle
redirect_valid  input  1  taken branch/jump; overrides everything except reset
redirect_target  input  REG_BITS  new PC; alignment bits forced to 0 (bits[1:0] if INC==4, bit[0] if INC==2)
imem_req  output  1  fetch request, held high until ack or abort
imem_addr  output  REG_BITS  fetch address, equals pc_out while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0
imem_rdata  input  REG_BITS  fetched instruction word
inst_valid  output  1  inst/inst_pc valid for decode
inst  output  REG_BITS  held instruction
inst_pc  output  REG_BITS  address of held instruction
pc_out  output  REG_BITS  current PC register
fetch_count  output  32  count of instructions delivered to decode, wraps 2^32-1 -> 0

Behaviour:
- Reset (async, rst_n=0): state=BOOT, pc=RESET_VECTOR, imem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_count=0. Applies immediately mid-fetch or mid-hold; any ack in flight is lost.
- All outputs are registered except imem_addr (=pc) and imem_req (decoded from state==FETCH).
- States:
  - BOOT: one cycle after rst_n deasserts, then FETCH. A redirect in BOOT loads pc=target and still goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - redirect_valid=1: pc<=aligned target, ack/rdata this cycle discarded, stay FETCH. imem_req drops for 0 cycles; the memory sees a changed address, which is the abort.
    - else imem_ack=1: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+INC (mod 2^REG_BITS, wraps silently), go HOLD.
    - else: stay, hold address stable.
  - HOLD: imem_req=0, inst_valid=1.
    - redirect_valid=1: inst_valid<=0, pc<=aligned target, fetch_count unchanged, go FETCH. The redirect wins over consumption.
    - else stall=0: instruction consumed at this edge, fetch_count<=fetch_count+1, inst_valid<=0, go FETCH.
    - else stall=1: hold inst, inst_pc, inst_valid unchanged.
- Minimum latency: req to inst_valid is 1 cycle after the ack edge. Best throughput is 1 instruction per 2 cycles (FETCH with immediate ack, then HOLD with stall=0).
- Redirect arriving in the same cycle as ack: the redirect wins and the instruction is never presented.
- stall is ignored outside HOLD. imem_ack outside FETCH is ignored.
- fetch_count increments only on consumption (HOLD, stall=0, no redirect).

Test Plan:
- Reset/boot, RESET_VECTOR=0x100, REG_BITS=32, ack every FETCH cycle, stall=0 -> imem_addr sequence 0x100,0x104,0x108 on successive FETCH cycles; inst_pc matches; fetch_count=3 after the third HOLD.
- Ack delayed 3 cycles -> imem_req high and imem_addr=0x100 stable for 4 cycles; inst_valid rises the cycle after ack.
- HOLD with stall=1 for 5 cycles -> inst/inst_pc/inst_valid unchanged, imem_req=0, fetch_count unchanged; stall=0 -> count+1, next FETCH addr=inst_pc+4.
- redirect_valid with target 0x203 in the same cycle as imem_ack at 0x104 -> rdata dropped, inst_valid stays 0, next imem_addr=0x200; redirect during HOLD -> inst_valid falls, fetch_count not incremented.
- REG_BITS=16, pc=0xFFFE, ack -> pc wraps to 0x0000, inst_pc=0xFFFE; redirect target 0x0011 -> pc=0x0010.
- rst_n asserted mid-FETCH with ack pending, and separately during HOLD -> outputs return to reset values immediately; after release, one BOOT cycle, then imem_addr=RESET_VECTOR.
